// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of one shared fifo; also sequences the fifo flush pulse and hold window.
// Optional requester lock (sticky grant) is built when FIFO_ARB_LOCK_EN is defined.
module fifo_push_arbiter #(
   parameter int NREQ     = 4,
   parameter int DW       = 64,
   parameter int HOLD_CYC = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DW-1:0]       req_data,
   output logic [NREQ-1:0]          req_ready,
`ifdef FIFO_ARB_LOCK_EN
   input  logic [NREQ-1:0]          req_lock,
`endif
   input  logic                     flush_req,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     fifo_push,
   output logic [DW-1:0]            fifo_push_data,
   input  logic                     fifo_ready,
   output logic                     fifo_flush
);

   localparam int IW = $clog2(NREQ);
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [3:0] HOLD_LOAD = 4'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);

   logic [1:0]      state_reg, state_next;
   logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [3:0]      hold_cnt_reg, hold_cnt_next;

   logic            en;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic            found;
   logic [IW:0]     scan_sum;
   logic [IW-1:0]   scan_idx;
   logic [DW-1:0]   masked_data [NREQ];
   logic [DW-1:0]   push_data;

   // A push in the same cycle as a flush request would be discarded by the flush, so none is granted.
   assign en = (state_reg == ST_RUN) & ~flush_req & fifo_ready & ~rst;

`ifdef FIFO_ARB_LOCK_EN
   logic            lock_active_reg, lock_active_next;
   logic [IW-1:0]   lock_id_reg, lock_id_next;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
         assign eligible[gi] = req_valid[gi] & (~lock_active_reg | (lock_id_reg == IW'(gi)));
      end
   endgenerate
`else
   assign eligible = req_valid;
`endif

   // Scan from rr_ptr upward, wrapping at NREQ; the first eligible requester wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, rr_ptr_reg} + (IW+1)'(k);
         if (scan_sum >= (IW+1)'(NREQ)) begin
            scan_sum = scan_sum - (IW+1)'(NREQ);
         end
         scan_idx = scan_sum[IW-1:0];
         if (en && !found && eligible[scan_idx]) begin
            found           = 1'b1;
            grant_idx       = scan_idx;
            grant[scan_idx] = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
         assign masked_data[gi] = req_data[gi*DW +: DW] & {DW{grant[gi]}};
      end
   endgenerate

   always_comb begin
      push_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         push_data = push_data | masked_data[k];
      end
   end

   assign req_ready      = grant;
   assign fifo_push      = found;
   assign fifo_push_data = push_data;
   assign grant_id       = grant_idx;
   assign fifo_flush     = (state_reg == ST_FLUSH);
   assign busy           = (state_reg != ST_RUN);

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      rr_ptr_next   = rr_ptr_reg;
      if (found) begin
         rr_ptr_next = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      case (state_reg)
         ST_RUN: begin
            if (flush_req) begin
               state_next  = ST_FLUSH;
               rr_ptr_next = '0;
            end
         end
         ST_FLUSH: begin
            if (flush_req) begin
               state_next = ST_FLUSH;
            end else if (HOLD_CYC == 0) begin
               state_next = ST_RUN;
            end else begin
               state_next    = ST_HOLD;
               hold_cnt_next = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (flush_req) begin
               state_next  = ST_FLUSH;
               rr_ptr_next = '0;
            end else if (hold_cnt_reg == 4'd0) begin
               state_next = ST_RUN;
            end else begin
               hold_cnt_next = hold_cnt_reg - 4'd1;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

`ifdef FIFO_ARB_LOCK_EN
   // Every transfer re-decides the lock from the granted requester's lock bit; any flush drops it.
   always_comb begin
      lock_active_next = lock_active_reg;
      lock_id_next     = lock_id_reg;
      if (found) begin
         lock_active_next = req_lock[grant_idx];
         lock_id_next     = grant_idx;
      end
      if (state_next == ST_FLUSH) begin
         lock_active_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_active_reg <= 1'b0;
         lock_id_reg     <= '0;
      end else begin
         lock_active_reg <= lock_active_next;
         lock_id_reg     <= lock_id_next;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_RUN;
         rr_ptr_reg   <= '0;
         hold_cnt_reg <= 4'd0;
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold_chk
         a_valid_held: assert property (@(posedge clk) disable iff (rst)
            (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
      end
   endgenerate

   a_one_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_push_legal: assert property (@(posedge clk) disable iff (rst)
      fifo_push |-> (fifo_ready && state_reg == ST_RUN));

endmodule
